// File: rtl/gameplay_pkg.sv
// Shared state encoding, status codes, default sizes and the level helper
// for gameplay_control_param and its counter block.
package gameplay_pkg;

  typedef enum logic [3:0] {
    S_INIT, S_PREP, S_MOVE, S_HOLD, S_JUDGE, S_SUCCESS, S_FAIL,
    S_PAUSED, S_LOST, S_LOST_KEY, S_WON, S_WON_KEY
  } state_t;

  localparam logic [1:0] ST_PAUSED = 2'b00;
  localparam logic [1:0] ST_PLAY   = 2'b01;
  localparam logic [1:0] ST_LOST   = 2'b10;
  localparam logic [1:0] ST_WON    = 2'b11;

  localparam int DEF_NUM_ROWS = 16;
  localparam int DEF_CHANCES  = 3;
  localparam int DEF_SCORE_W  = 8;

  function automatic logic [1:0] level_for(int successes, int per_level, int max_level);
    int l;
    l = successes / per_level;
    if (l > max_level) l = max_level;
    return l[1:0];
  endfunction

endpackage

// File: rtl/gameplay_counters.sv
// Row/score/chance/level counters driven by one-cycle FSM strobes.
// Optional GAMEPLAY_DROP_TIMEOUT_EN adds the MOVE-state drop timer.
module gameplay_counters import gameplay_pkg::*; #(
  parameter int NUM_ROWS       = DEF_NUM_ROWS,
  parameter int CHANCES        = DEF_CHANCES,
  parameter int SCORE_W        = DEF_SCORE_W,
  parameter int ROWS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 3,
  parameter int DROP_TIMEOUT   = 500
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         inc,
  input  logic                         dec,
  input  logic                         tmr_clr,
  input  logic                         tmr_run,
  output logic [$clog2(NUM_ROWS)-1:0]  row,
  output logic [SCORE_W-1:0]           score,
  output logic [$clog2(CHANCES+1)-1:0] chances_left,
  output logic [1:0]                   level,
  output logic                         at_top,
  output logic                         last_chance,
  output logic                         drop
);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int CH_W  = $clog2(CHANCES+1);

  assign at_top      = (row == ROW_W'(NUM_ROWS-1));
  assign last_chance = (chances_left == CH_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row          <= '0;
      score        <= '0;
      chances_left <= CH_W'(CHANCES);
      level        <= '0;
    end else if (clr) begin
      row          <= '0;
      score        <= '0;
      chances_left <= CH_W'(CHANCES);
      level        <= '0;
    end else begin
      if (inc) begin
        if (score != '1) score <= score + SCORE_W'(1);
        if (!at_top)     row   <= row + ROW_W'(1);
        // successes so far equal row+1; the top row is held on a win
        level <= level_for(int'(row) + 1, ROWS_PER_LEVEL, MAX_LEVEL);
      end
      if (dec && chances_left != '0) chances_left <= chances_left - CH_W'(1);
    end
  end

`ifdef GAMEPLAY_DROP_TIMEOUT_EN
  localparam int TW = $clog2(DROP_TIMEOUT+1);
  logic [TW-1:0] tmr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         tmr <= '0;
    else if (tmr_clr)                                  tmr <= '0;
    else if (tmr_run && tmr != TW'(DROP_TIMEOUT-1))    tmr <= tmr + TW'(1);
  end

  assign drop = tmr_run && (tmr == TW'(DROP_TIMEOUT-1));
`else
  localparam int unused_drop_timeout = DROP_TIMEOUT;
  logic unused_tmr;
  assign unused_tmr = tmr_clr | tmr_run;
  assign drop       = 1'b0;
`endif

endmodule

// File: rtl/gameplay_control_param.sv
// Block-stacking game FSM: Moore strobes to the datapath, pause/resume, win/loss.
// Optional GAMEPLAY_DROP_TIMEOUT_EN forces a placement after DROP_TIMEOUT MOVE cycles.
module gameplay_control_param import gameplay_pkg::*; #(
  parameter int NUM_ROWS       = DEF_NUM_ROWS,
  parameter int CHANCES        = DEF_CHANCES,
  parameter int SCORE_W        = DEF_SCORE_W,
  parameter int ROWS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 3,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int DROP_TIMEOUT   = 500
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_place,
  input  logic                         pause,
  input  logic                         overlap,
  output logic                         ld_x,
  output logic                         ld_y,
  output logic                         ld_d,
  output logic                         enable,
  output logic                         save_x,
  output logic                         inc_row,
  output logic [$clog2(NUM_ROWS)-1:0]  row,
  output logic [SCORE_W-1:0]           score,
  output logic [$clog2(CHANCES+1)-1:0] chances_left,
  output logic [1:0]                   level,
  output logic [1:0]                   game_status
);
  state_t state, nxt, resume, place_nxt;
  logic   pressed, clr, inc, dec, tmr_clr, tmr_run, at_top, last_chance, drop;

  assign pressed   = (KEY_ACTIVE_LOW != 0) ? ~key_place : key_place;
  assign place_nxt = (row == '0) ? S_SUCCESS : S_JUDGE;

  gameplay_counters #(
    .NUM_ROWS(NUM_ROWS), .CHANCES(CHANCES), .SCORE_W(SCORE_W),
    .ROWS_PER_LEVEL(ROWS_PER_LEVEL), .MAX_LEVEL(MAX_LEVEL), .DROP_TIMEOUT(DROP_TIMEOUT)
  ) u_cnt (
    .clk(clk), .reset(reset), .clr(clr), .inc(inc), .dec(dec),
    .tmr_clr(tmr_clr), .tmr_run(tmr_run),
    .row(row), .score(score), .chances_left(chances_left), .level(level),
    .at_top(at_top), .last_chance(last_chance), .drop(drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_INIT;
      resume <= S_MOVE;
    end else begin
      state <= nxt;
      if ((state == S_MOVE || state == S_HOLD) && pause) resume <= state;
    end
  end

  always_comb begin
    nxt         = state;
    ld_x        = 1'b0;
    ld_y        = 1'b0;
    ld_d        = 1'b0;
    enable      = 1'b0;
    save_x      = 1'b0;
    inc_row     = 1'b0;
    clr         = 1'b0;
    inc         = 1'b0;
    dec         = 1'b0;
    tmr_clr     = 1'b0;
    tmr_run     = 1'b0;
    game_status = ST_PLAY;
    case (state)
      S_INIT: begin clr = 1'b1; nxt = S_PREP; end
      S_PREP: begin
        {ld_x, ld_y, ld_d} = 3'b111;
        tmr_clr = 1'b1;
        nxt = S_MOVE;
      end
      // pause takes priority over both the key and a timeout drop
      S_MOVE: begin
        enable  = 1'b1;
        tmr_run = 1'b1;
        if (pause)        nxt = S_PAUSED;
        else if (drop)    nxt = place_nxt;
        else if (pressed) nxt = S_HOLD;
      end
      S_HOLD: begin
        enable = 1'b1;
        if (pause)         nxt = S_PAUSED;
        else if (!pressed) nxt = place_nxt;
      end
      S_JUDGE: nxt = overlap ? S_SUCCESS : S_FAIL;
      S_SUCCESS: begin
        save_x  = 1'b1;
        inc_row = 1'b1;
        inc     = 1'b1;
        nxt     = at_top ? S_WON : S_PREP;
      end
      S_FAIL: begin
        dec = 1'b1;
        if (last_chance) nxt = S_LOST;
        else begin
          {ld_x, ld_y, ld_d} = 3'b111;
          tmr_clr = 1'b1;
          nxt = S_MOVE;
        end
      end
      S_PAUSED: begin
        game_status = ST_PAUSED;
        if (!pause) nxt = resume;
      end
      S_LOST:     begin game_status = ST_LOST; if (pressed)  nxt = S_LOST_KEY; end
      S_LOST_KEY: begin game_status = ST_LOST; if (!pressed) nxt = S_INIT;     end
      S_WON:      begin game_status = ST_WON;  if (pressed)  nxt = S_WON_KEY;  end
      S_WON_KEY:  begin game_status = ST_WON;  if (!pressed) nxt = S_INIT;     end
      default:    nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_gameplay_control_param.sv
// Randomized scoreboard bench for gameplay_control_param with a game-level reference model.
module tb_gameplay_control_param;
  localparam int NUM_ROWS = 4, CHANCES = 3, SCORE_W = 8, RPL = 4, MAXL = 3, DROP = 20;

  logic clk = 1'b0, reset = 1'b1, key_place = 1'b1, pause = 1'b0, overlap = 1'b0;
  logic ld_x, ld_y, ld_d, enable, save_x, inc_row;
  logic [1:0] row, chances_left, level, game_status;
  logic [SCORE_W-1:0] score;

  gameplay_control_param #(
    .NUM_ROWS(NUM_ROWS), .CHANCES(CHANCES), .SCORE_W(SCORE_W), .ROWS_PER_LEVEL(RPL),
    .MAX_LEVEL(MAXL), .KEY_ACTIVE_LOW(1), .DROP_TIMEOUT(DROP)
  ) dut (
    .clk(clk), .reset(reset), .key_place(key_place), .pause(pause), .overlap(overlap),
    .ld_x(ld_x), .ld_y(ld_y), .ld_d(ld_d), .enable(enable), .save_x(save_x), .inc_row(inc_row),
    .row(row), .score(score), .chances_left(chances_left), .level(level), .game_status(game_status)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int row; int score; int chances; int level; int status; } exp_t;
  exp_t exp_q[$];
  int   lat_q[$];
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b0;

  // reference game state
  int m_row, m_score, m_chances, m_level, m_succ, m_status;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void model_push();
    exp_q.push_back('{m_row, m_score, m_chances, m_level, m_status});
  endfunction

  function automatic void model_reset(input bit push);
    m_row = 0; m_score = 0; m_chances = CHANCES; m_level = 0; m_succ = 0; m_status = 1;
    if (push) model_push();
  endfunction

  function automatic void model_place(input bit ov);
    if (m_row == 0 || ov) begin
      m_succ++;
      if (m_score < (1 << SCORE_W) - 1) m_score++;
      m_level = (m_succ / RPL > MAXL) ? MAXL : m_succ / RPL;
      if (m_row == NUM_ROWS - 1) m_status = 3;
      else m_row++;
    end else begin
      m_chances--;
      if (m_chances == 0) m_status = 2;
    end
    model_push();
  endfunction

  task automatic wait_en(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (enable == lvl) begin ok = 1'b1; return; end
      @(negedge clk);
    end
    chk("enable_wait_timeout", int'(enable), int'(lvl));
  endtask

  task automatic wait_status(input int st, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (int'(game_status) == st) begin ok = 1'b1; return; end
      @(negedge clk);
    end
    chk("status_wait_timeout", int'(game_status), st);
  endtask

  // ov_mode: 0 random, 1 overlap, 2 no overlap
  task automatic do_place(input int ov_mode, input bit hold_pause);
    bit ok, ov;
    int ref_cyc, extra, lat;
    wait_en(1'b1, ok);
    if (!ok) return;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    if (!hold_pause && $urandom_range(0, 4) == 0) begin
      pause = 1'b1;
      repeat (3) @(negedge clk);
      chk("move_pause_enable", int'(enable), 0);
      chk("move_pause_status", int'(game_status), 0);
      pause = 1'b0;
      @(negedge clk);
    end
    ov = (ov_mode == 1) ? 1'b1 : (ov_mode == 2) ? 1'b0 : ($urandom_range(0, 1) != 0);
    overlap   = ov;
    key_place = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    if (hold_pause) begin
      pause = 1'b1;
      @(negedge clk);
      key_place = 1'b1;
      repeat (9) @(negedge clk);
      chk("hold_pause_enable", int'(enable), 0);
      chk("hold_pause_status", int'(game_status), 0);
      chk("hold_pause_no_place", int'(score), m_score);
      pause = 1'b0; ref_cyc = cyc; extra = 1;
    end else begin
      key_place = 1'b1; ref_cyc = cyc; extra = 0;
    end
    lat = (m_row == 0) ? 1 : 2;
    if (m_row == 0 || ov) lat_q.push_back(ref_cyc + extra + lat);
    model_place(ov);
    repeat (1 + extra) @(negedge clk);
    if (m_status != 1) begin
      wait_status(m_status, ok);
      key_place = 1'b0;
      repeat (2) @(negedge clk);
      key_place = 1'b1;
      model_reset(1'b1);
      @(negedge clk);
    end
  endtask

  // monitor: every counter update and inc_row pulse is matched against the queues
  initial begin
    logic [13:0] cur, prev;
    exp_t e;
    int t;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {row, score, chances_left, level};
      if (mon_en) begin
        if (cur != prev) begin
          chk("update_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("row", int'(row), e.row);
            chk("score", int'(score), e.score);
            chk("chances_left", int'(chances_left), e.chances);
            chk("level", int'(level), e.level);
            chk("game_status", int'(game_status), e.status);
          end
        end
        if (inc_row) begin
          chk("inc_row_expected", int'(lat_q.size() > 0), 1);
          if (lat_q.size() > 0) begin
            t = lat_q.pop_front();
            chk("inc_row_cycle", cyc, t);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    int m;
    repeat (3) @(negedge clk);
    chk("rst_row", int'(row), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_chances", int'(chances_left), CHANCES);
    chk("rst_level", int'(level), 0);
    chk("rst_status", int'(game_status), 1);
    chk("rst_strobes", int'({ld_x, ld_y, ld_d, enable, save_x, inc_row}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("prep_ld", int'({ld_x, ld_y, ld_d}), 7);
    chk("prep_enable", int'(enable), 0);
    @(negedge clk);
    chk("move_enable", int'(enable), 1);
    chk("move_ld", int'(ld_x), 0);
    model_reset(1'b0);
    mon_en = 1'b1;

`ifdef GAMEPLAY_DROP_TIMEOUT_EN
    m = cyc;
    lat_q.push_back(m + DROP);
    model_place(1'b0);
    wait_en(1'b0, ok);
    wait_en(1'b1, ok);
    m = cyc;
    overlap = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b1;
    repeat (5) @(negedge clk);
    pause = 1'b0;
    lat_q.push_back(m + DROP + 5 + 1);
    model_place(1'b1);
`else
    m = cyc;
`endif

    do_place(1, 1'b0);
    do_place(1, 1'b1);
    repeat (3) do_place(2, 1'b0);
    repeat (4) do_place(1, 1'b0);
    for (int i = 0; i < 40; i++) do_place(0, $urandom_range(0, 5) == 0);

    repeat (6) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("lat_q_drained", lat_q.size(), 0);

    mon_en = 1'b0;
    wait_en(1'b1, ok);
    key_place = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_row", int'(row), 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_chances", int'(chances_left), CHANCES);
    chk("midrst_status", int'(game_status), 1);
    chk("midrst_strobes", int'({ld_x, ld_y, ld_d, enable, save_x, inc_row}), 0);
    @(negedge clk);
    reset = 1'b0; key_place = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
